// File: rtl/my_mux_stream.sv
// Purpose  : 2:1 round-robin stream merge. Each word carries a source tag (out_sel).
// Latency  : one cycle from a source transfer to out_valid.
// Backpr.  : one-entry output register. It reloads when empty or draining, so a
//            stalled output drops both readies and priority does not rotate.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   a_data/a_valid/a_ready source A channel (tag 0)
//   b_data/b_valid/b_ready source B channel (tag 1)
//   out_data/out_sel      registered merged word and its source tag
//   out_valid/out_ready   output handshake
module my_mux_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    // Tag of the most recent winner. The other side wins the next tie.
    logic             last_sel_q, last_sel_d;

    logic load_en;
    logic grant_a;
    logic grant_b;

    // The register can take a word when it is empty or is draining this edge.
    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_a = last_sel_q;
            grant_b = !last_sel_q;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    // Readies are held low during reset, so no source sees a transfer then.
    assign a_ready = load_en && grant_a && !reset;
    assign b_ready = load_en && grant_b && !reset;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        last_sel_d  = last_sel_q;
        if (load_en) begin
            if (grant_a || grant_b) begin
                out_data_d  = grant_b ? b_data : a_data;
                out_sel_d   = grant_b;
                out_valid_d = 1'b1;
                last_sel_d  = grant_b;
            end else begin
                // Drained with nothing to replace it. Data and tag keep stale values.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            last_sel_q  <= 1'b1;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            last_sel_q  <= last_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_my_mux_stream.sv
// Purpose  : randomized and directed checking of my_mux_stream against a
//            transaction-level model (output slot queue, winner rules, per-source
//            scoreboards for the demux round trip).
module tb_my_mux_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [15:0] out_data;
    logic        out_sel;
    logic        out_valid;
    logic        out_ready;

    my_mux_stream #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [15:0] data;
    } word_t;

    word_t       slot[$];      // words the model expects in the output register
    logic        m_last;       // source that won most recently
    logic [15:0] sent_a[$];    // words accepted from A, not yet seen leaving
    logic [15:0] sent_b[$];
    logic        a_taken, b_taken;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One clock cycle. Check the DUT outputs against the model, take the edge,
    // then advance the model. The caller drives the inputs beforehand.
    task automatic step();
        logic  le, ga, gb, ov, os;
        logic [15:0] od, head;
        word_t w;
        #1;
        le = !reset && (slot.size() == 0 || out_ready);
        if (a_valid && b_valid) begin
            ga = (m_last == 1'b1);   // the side that did not win last time
            gb = (m_last == 1'b0);
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
        chk("a_ready", a_ready, le && ga);
        chk("b_ready", b_ready, le && gb);
        chk("out_valid", out_valid, slot.size() != 0);
        if (slot.size() != 0) begin
            chk("out_data", out_data, slot[0].data);
            chk("out_sel", out_sel, slot[0].sel);
        end
        ov = out_valid; od = out_data; os = out_sel;
        a_taken = a_valid && a_ready;
        b_taken = b_valid && b_ready;
        if (a_taken) sent_a.push_back(a_data);
        if (b_taken) sent_b.push_back(b_data);
        @(posedge clk);
        if (reset) begin
            slot.delete();
            sent_a.delete();
            sent_b.delete();
            m_last = 1'b1;
        end else begin
            // The demux side: a drained word must be the oldest one from its tagged source.
            if (ov && out_ready) begin
                if (os) begin
                    if (sent_b.size() == 0) chk("rt_b_extra", 1, 0);
                    else begin head = sent_b.pop_front(); chk("rt_b", od, head); end
                end else begin
                    if (sent_a.size() == 0) chk("rt_a_extra", 1, 0);
                    else begin head = sent_a.pop_front(); chk("rt_a", od, head); end
                end
            end
            if (slot.size() != 0 && out_ready) void'(slot.pop_front());
            if (le && (ga || gb)) begin
                w.sel  = gb;
                w.data = gb ? b_data : a_data;
                slot.push_back(w);
                m_last = gb;
            end
        end
        #1;
    endtask

    initial begin
        m_last = 1'b1;
        a_taken = 1'b0; b_taken = 1'b0;
        reset = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_data = 16'h0A0A; b_data = 16'h0B0B;

        // Reset held two cycles with both sources valid.
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post_reset_first_a", a_ready, 1);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // Single active source A streams 1..4 back to back.
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_data = 16'(i);
            step();
            chk("single_data", out_data, i);
            chk("single_sel", out_sel, 0);
        end
        a_valid = 1'b0;
        step();

        // Continuous contention alternates A, B, A, B starting from reset priority.
        reset = 1'b1; step(); reset = 1'b0;
        a_valid = 1'b1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_data = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_sel", out_sel, i % 2);
            chk("cont_data", out_data, (i % 2) ? 32'hBBBB : 32'hAAAA);
        end

        // Backpressure: 1234 held while the output stalls, and priority does not rotate.
        reset = 1'b1; step(); reset = 1'b0;
        b_valid = 1'b0; a_data = 16'h1234;
        step();
        a_data = 16'h1111; b_valid = 1'b1; b_data = 16'h2222;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", out_data, 16'h1234);
        end
        out_ready = 1'b1;
        #1;
        chk("stall_b_wins", b_ready, 1);
        chk("stall_a_waits", a_ready, 0);
        step();
        chk("stall_reload", out_data, 16'h2222);
        b_valid = 1'b0;
        step();
        a_valid = 1'b0;
        step();

        // Reset while the output holds 5678: the word is discarded.
        a_valid = 1'b1; a_data = 16'h5678;
        step();
        a_valid = 1'b0; out_ready = 1'b0;
        chk("hold_5678", out_data, 16'h5678);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_data", out_data, 0);
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 16'hC0DE; b_valid = 1'b1; b_data = 16'hD00D;
        #1;
        chk("mid_reset_tie_a", a_ready, 1);
        step();
        a_valid = 1'b0;
        step();
        b_valid = 1'b0;
        step();

        // Random traffic, random backpressure and occasional resets.
        a_taken = 1'b0; b_taken = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!a_valid || a_taken) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_data  = 16'($urandom);
            end
            if (!b_valid || b_taken) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_data  = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end

        // Drain: nothing lost or left behind.
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("no_loss", sent_a.size() + sent_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
